// File: rtl/moo_core_seq.sv
// moo_core_seq: iterative rotate/XOR block cipher core.
// Round keys are expanded one per cycle, and one round is processed per cycle.
module moo_core_seq #(
   parameter int BLOCK_W = 32,
   parameter int ROUNDS  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               keygen,
   input  logic               encrypt,
   input  logic               decrypt,
   input  logic [BLOCK_W-1:0] key_in,
   input  logic [BLOCK_W-1:0] din,
   input  logic               din_valid,
   output logic               core_ready,
   output logic               core_done,
   output logic [BLOCK_W-1:0] dout,
   output logic               err
);
   localparam int IW = $clog2(ROUNDS);
   localparam logic [IW-1:0] LAST = IW'(ROUNDS - 1);
   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      KEYEXP = 5'b00010,
      READY  = 5'b00100,
      BUSY   = 5'b01000,
      DONE   = 5'b10000
   } state_t;
   state_t state, nxt;
   logic [BLOCK_W-1:0] rk [ROUNDS];
   logic [BLOCK_W-1:0] s, k, t, p, s_nxt, rk_nxt;
   logic [IW-1:0] idx, rnd;
   logic keygen_q, kg_arm, kg_rise, dir, acc, bad;

   // kg_arm stays low until keygen has been seen low, so a level held through reset cannot trigger
   assign kg_rise    = keygen & ~keygen_q & kg_arm;
   assign core_ready = state == READY;
   assign core_done  = state == DONE;

   always_comb begin
      p      = rk[idx - IW'(1)];
      rk_nxt = {p[BLOCK_W-4:0], p[BLOCK_W-1:BLOCK_W-3]} ^ BLOCK_W'(idx);
      k      = rk[dir ? LAST - rnd : rnd];
      t      = s ^ k;
      s_nxt  = dir ? {s[0], s[BLOCK_W-1:1]} ^ k : {t[BLOCK_W-2:0], t[BLOCK_W-1]};
   end

   always_comb begin
      nxt = state;
      acc = 1'b0;
      bad = 1'b0;
      if (kg_rise) nxt = KEYEXP;
      else case (state)
         KEYEXP:  nxt = idx == LAST ? READY : KEYEXP;
         READY: if (din_valid) begin
            acc = encrypt ^ decrypt;
            bad = ~acc;
            nxt = acc ? BUSY : READY;
         end
         BUSY:    nxt = rnd == LAST ? DONE : BUSY;
         DONE:    nxt = READY;
         default: nxt = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         keygen_q <= 1'b0;
         kg_arm   <= ~keygen;
         idx      <= '0;
         rnd      <= '0;
         s        <= '0;
         dir      <= 1'b0;
         dout     <= '0;
         err      <= 1'b0;
         for (int i = 0; i < ROUNDS; i++) rk[i] <= '0;
      end else begin
         keygen_q <= keygen;
         kg_arm   <= kg_arm | ~keygen;
         err      <= bad;
         if (kg_rise) begin
            rk[0] <= key_in;
            idx   <= IW'(1);
         end else if (state == KEYEXP) begin
            rk[idx] <= rk_nxt;
            idx     <= idx + IW'(1);
         end
         if (acc) begin
            s   <= din;
            dir <= decrypt;
            rnd <= '0;
         end else if (state == BUSY) begin
            s   <= s_nxt;
            rnd <= rnd + IW'(1);
            if (rnd == LAST) dout <= s_nxt;
         end
      end
   end
endmodule

// File: tb/tb_moo_core_seq.sv
// tb_moo_core_seq: directed checks of key expansion, encrypt/decrypt, errors, abort and reset.
module tb_moo_core_seq;
   logic        clk = 1'b0, rst = 1'b1, keygen = 1'b0, encrypt = 1'b0, decrypt = 1'b0, din_valid = 1'b0;
   logic [31:0] key_in = '0, din = '0;
   logic        core_ready, core_done, err;
   logic [31:0] dout;
   int checks = 0, failures = 0;

   moo_core_seq #(.BLOCK_W(32), .ROUNDS(4)) dut (
      .clk(clk), .rst(rst), .keygen(keygen), .encrypt(encrypt), .decrypt(decrypt),
      .key_in(key_in), .din(din), .din_valid(din_valid),
      .core_ready(core_ready), .core_done(core_done), .dout(dout), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offer one block, flip the direction and make a stray offer while busy, then check latency and result
   task automatic run_block(input string tag, input logic dec, input logic [31:0] d, input logic [31:0] exp);
      int n;
      din = d; encrypt = ~dec; decrypt = dec; din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0; encrypt = dec; decrypt = ~dec; din = ~d;
      check({tag, "_busy_ready"}, 32'(core_ready), 32'd0);
      tick(1);
      din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0;
      n = 3;
      while (!core_done && n < 20) begin
         tick(1);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd5);
      check({tag, "_dout"}, dout, exp);
      tick(1);
      check({tag, "_done_width"}, 32'(core_done), 32'd0);
      check({tag, "_ready_again"}, 32'(core_ready), 32'd1);
      check({tag, "_dout_held"}, dout, exp);
   endtask

   initial begin
      tick(2);
      check("rst_ready", 32'(core_ready), 32'd0);
      check("rst_done", 32'(core_done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_dout", dout, 32'd0);
      rst = 1'b0;
      din_valid = 1'b1; encrypt = 1'b1;
      tick(3);
      check("idle_ready", 32'(core_ready), 32'd0);
      check("idle_done", 32'(core_done), 32'd0);
      din_valid = 1'b0; encrypt = 1'b0;

      keygen = 1'b1; key_in = 32'h0;
      tick(3);
      check("kg0_ready_c3", 32'(core_ready), 32'd0);
      tick(1);
      check("kg0_ready_c4", 32'(core_ready), 32'd1);
      key_in = 32'hFFFF_FFFF;
      run_block("enc0", 1'b0, 32'h0000_0000, 32'h0000_0086);
      run_block("dec0", 1'b1, 32'h0000_0086, 32'h0000_0000);

      din_valid = 1'b1; encrypt = 1'b1; decrypt = 1'b1;
      tick(1);
      din_valid = 1'b0;
      check("err_both_pulse", 32'(err), 32'd1);
      check("err_both_ready", 32'(core_ready), 32'd1);
      tick(1);
      check("err_both_clear", 32'(err), 32'd0);
      check("err_both_stay", 32'(core_ready), 32'd1);
      encrypt = 1'b0; decrypt = 1'b0; din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0;
      check("err_none_pulse", 32'(err), 32'd1);
      tick(1);
      check("err_none_clear", 32'(err), 32'd0);
      check("kg_held_ready", 32'(core_ready), 32'd1);

      keygen = 1'b0;
      tick(1);
      din = 32'h0; encrypt = 1'b1; decrypt = 1'b0; din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0;
      tick(1);
      keygen = 1'b1; key_in = 32'h1234_5678;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check($sformatf("abort_done_c%0d", i), 32'(core_done), 32'd0);
         if (i <= 4) check($sformatf("abort_ready_c%0d", i), 32'(core_ready), 32'(i == 4));
      end
      run_block("enc1", 1'b0, 32'h1234_5678, 32'h681A_06D8);
      run_block("dec1", 1'b1, 32'h681A_06D8, 32'h1234_5678);

      din = 32'h0; encrypt = 1'b1; decrypt = 1'b0; din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      check("rstb_ready", 32'(core_ready), 32'd0);
      check("rstb_done", 32'(core_done), 32'd0);
      check("rstb_err", 32'(err), 32'd0);
      check("rstb_dout", dout, 32'd0);
      tick(1);
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         check($sformatf("post_rst_idle_c%0d", i), {30'd0, core_ready, core_done}, 32'd0);
      end
      keygen = 1'b0; key_in = 32'h0;
      tick(1);
      keygen = 1'b1;
      tick(4);
      check("kg2_ready_c4", 32'(core_ready), 32'd1);
      run_block("enc2", 1'b0, 32'h0000_0000, 32'h0000_0086);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/moo_core_seq.md
MOO_CORE_SEQ -- requirements
Module: moo_core_seq

Interface
REQ-001 Parameter BLOCK_W, default 32: width of block and key.
REQ-002 Parameter ROUNDS, default 4: round count, range 2..16.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port keygen, input, 1: level from mode controller; a rising edge requests key expansion.
REQ-006 Port encrypt, input, 1: level from mode controller; selects the encrypt direction.
REQ-007 Port decrypt, input, 1: level from mode controller; selects the decrypt direction.
REQ-008 Port key_in, input, BLOCK_W: cipher key, sampled on the keygen rising edge.
REQ-009 Port din, input, BLOCK_W: input block, sampled when a block is accepted.
REQ-010 Port din_valid, input, 1: block offer; qualified by core_ready.
REQ-011 Port core_ready, output, 1: registered; high only in READY.
REQ-012 Port core_done, output, 1: registered; one-cycle pulse at block completion.
REQ-013 Port dout, output, BLOCK_W: registered result, held until the next completion.
REQ-014 Port err, output, 1: registered; one-cycle pulse on an illegal command.

Function
REQ-015 States SHALL be IDLE, KEYEXP, READY, BUSY, DONE; one-hot encoding.
REQ-016 Keygen edge: kg_rise = keygen & ~keygen_q, with keygen_q a registered copy of keygen.
REQ-017 In any state, kg_rise SHALL latch rk[0]=key_in, set idx=1 and enter KEYEXP; this aborts any block in flight with no core_done.
REQ-018 KEYEXP SHALL compute one round key per cycle, rk[idx]=rotl(rk[idx-1],3) XOR idx (idx zero-extended); idx increments each cycle.
REQ-019 After rk[ROUNDS-1] is written, the block SHALL enter READY. core_ready rises exactly ROUNDS cycles after the kg_rise cycle.
REQ-020 In READY, din_valid with exactly one of encrypt/decrypt high SHALL latch din and the direction, clear the round counter and enter BUSY.
REQ-021 In READY, din_valid with encrypt and decrypt both high or both low SHALL pulse err for one cycle and stay in READY; nothing is latched.
REQ-022 BUSY encrypt round i=0..ROUNDS-1: s = rotl(s XOR rk[i],1).
REQ-023 BUSY decrypt round i=ROUNDS-1..0: s = rotr(s,1) XOR rk[i].
REQ-024 After ROUNDS BUSY cycles the block SHALL enter DONE. In the same edge dout<=s and core_done<=1 for exactly one cycle; the next state is READY.
REQ-025 Latency: block accepted at edge T -> core_done high in cycle T+ROUNDS+1 -> core_ready high again in cycle T+ROUNDS+2.
REQ-026 din_valid outside READY SHALL be ignored; there is no queueing.
REQ-027 encrypt/decrypt changes during BUSY SHALL NOT affect the block in flight.
REQ-028 In IDLE, din_valid SHALL be ignored and core_ready is 0 (no key loaded).
REQ-029 A level keygen held high SHALL NOT retrigger expansion; only a new rising edge does.
REQ-030 All rotate and XOR arithmetic is modulo 2^BLOCK_W; no carries.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, core_ready=0, core_done=0, err=0, dout=0, idx=0, keygen_q=0. rk is cleared to 0.
REQ-032 A reset during KEYEXP or BUSY SHALL discard all progress; no core_done is issued afterwards.
REQ-033 keygen high while rst is high SHALL NOT start expansion after rst releases unless keygen is first seen low.

Verification (BLOCK_W=32, ROUNDS=4)
REQ-034 kg_rise with key_in=0 -> rk={0x0,0x1,0xA,0x53}; core_ready rises 4 cycles later.
REQ-035 With that key, encrypt, din=0x00000000 -> core_done 5 cycles after acceptance, dout=0x00000086.
REQ-036 Decrypt, din=0x00000086, same key -> dout=0x00000000; core_done is exactly one cycle wide.
REQ-037 Further checks:
- din_valid with encrypt=decrypt=1 in READY -> err pulse, no BUSY, core_ready stays 1.
- A new keygen edge two cycles into BUSY -> no core_done; re-expansion; core_ready returns after 4 cycles.
- rst asserted mid-BUSY -> all outputs 0 next cycle; state IDLE.
REQ-038 keygen held high through READY -> no re-expansion; core_ready stays 1.
